// File: rtl/pr_key_extractor.sv
`default_nettype none
// ============================================================================
// Module  : pr_key_extractor
// Brief   : Parses TAG/LEN/payload/trailer byte frames into MSB-first search
//           keys behind a first-word fall-through FIFO.
//           Optional feature macro: PR_TRAILER_CHECK_EN (adds err_trl).
// Revision: 1.0 - initial release
// ============================================================================
module pr_key_extractor #(
   parameter int KEY_W      = 24,
   parameter int MAX_LEN    = 1024,
   parameter int FIFO_DEPTH = 4
`ifdef PR_TRAILER_CHECK_EN
   ,
   parameter logic [7:0] TRAILER = 8'hFF
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       s_data,
   input  logic             s_valid,
   input  logic             s_sop,
   output logic             s_ready,
   output logic [KEY_W-1:0] m_key,
   output logic [15:0]      m_tag,
   output logic [1:0]       m_bytes,
   output logic             m_last,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             err_len,
   output logic [15:0]      frame_cnt
`ifdef PR_TRAILER_CHECK_EN
   ,
   output logic             err_trl
`endif
);

   localparam int c_KB = KEY_W / 8;
   localparam int c_AW = $clog2(FIFO_DEPTH);
   localparam int c_CW = c_AW + 1;
   localparam int c_EW = KEY_W + 16 + 2 + 1;
   localparam logic [c_AW:0] c_FULL = FIFO_DEPTH[c_AW:0];

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_PAY  = 3'd2,
      ST_TRL  = 3'd3,
      ST_DROP = 3'd4
   } state_t;

   state_t           r_state;
   logic [1:0]       r_hcnt;
   logic [7:0]       r_len_hi;
   logic [15:0]      r_tag;
   logic [15:0]      r_rem;
   logic [KEY_W-1:0] r_key;
   logic [1:0]       r_kcnt;
   logic             r_err_len;
   logic [15:0]      r_frame_cnt;
`ifdef PR_TRAILER_CHECK_EN
   logic             r_err_trl;
`endif

   logic [c_EW-1:0]  r_mem [FIFO_DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_AW:0]    r_count;

   logic             w_full;
   logic             w_acc;
   logic             w_pop;
   logic             w_pay_byte;
   logic             w_final;
   logic             w_kfull;
   logic             w_push;
   logic [15:0]      w_len;
   logic             w_len_bad;
   logic [KEY_W-1:0] w_key_nx;
   logic [c_EW-1:0]  w_entry;

   // Backpressure only matters where a byte can push a key.
   assign w_full     = (r_count == c_FULL);
   assign s_ready    = ~rst & (~w_full | (r_state != ST_PAY));
   assign w_acc      = s_valid & s_ready;
   assign w_pop      = m_valid & m_ready;
   assign w_pay_byte = w_acc & ~s_sop & (r_state == ST_PAY);
   assign w_final    = (r_rem == 16'd1);
   assign w_kfull    = (r_kcnt == 2'(c_KB - 1));
   assign w_push     = w_pay_byte & (w_final | w_kfull);
   assign w_len      = {r_len_hi, s_data};
   assign w_len_bad  = (w_len == 16'd0) | ({16'd0, w_len} > MAX_LEN);
   assign w_entry    = {w_key_nx, r_tag, r_kcnt + 2'd1, w_final};

   always_comb begin
      w_key_nx = r_key;
      for (int i = 0; i < c_KB; i++) begin
         if (r_kcnt == 2'(i)) w_key_nx[KEY_W-1-8*i -: 8] = s_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_hcnt      <= 2'd0;
         r_len_hi    <= 8'd0;
         r_tag       <= 16'd0;
         r_rem       <= 16'd0;
         r_key       <= '0;
         r_kcnt      <= 2'd0;
         r_err_len   <= 1'b0;
         r_frame_cnt <= 16'd0;
`ifdef PR_TRAILER_CHECK_EN
         r_err_trl   <= 1'b0;
`endif
      end else begin
         r_err_len <= 1'b0;
`ifdef PR_TRAILER_CHECK_EN
         r_err_trl <= 1'b0;
`endif
         if (w_push && w_final) r_frame_cnt <= r_frame_cnt + 16'd1;
         if (w_acc) begin
            if (s_sop) begin
               // A start byte always restarts parsing; it is an abort unless idle.
               r_err_len   <= (r_state == ST_HDR) || (r_state == ST_PAY) || (r_state == ST_TRL);
               r_tag[15:8] <= s_data;
               r_hcnt      <= 2'd0;
               r_key       <= '0;
               r_kcnt      <= 2'd0;
               r_state     <= ST_HDR;
            end else begin
               case (r_state)
                  ST_HDR: begin
                     r_hcnt <= r_hcnt + 2'd1;
                     case (r_hcnt)
                        2'd0:    r_tag[7:0] <= s_data;
                        2'd1:    r_len_hi   <= s_data;
                        default: begin
                           r_rem <= w_len;
                           if (w_len_bad) begin
                              r_err_len <= 1'b1;
                              r_state   <= ST_DROP;
                           end else begin
                              r_state   <= ST_PAY;
                           end
                        end
                     endcase
                  end
                  ST_PAY: begin
                     r_rem <= r_rem - 16'd1;
                     if (w_push) begin
                        r_key  <= '0;
                        r_kcnt <= 2'd0;
                     end else begin
                        r_key  <= w_key_nx;
                        r_kcnt <= r_kcnt + 2'd1;
                     end
                     if (w_final) r_state <= ST_TRL;
                  end
                  ST_TRL: begin
`ifdef PR_TRAILER_CHECK_EN
                     r_err_trl <= (s_data != TRAILER);
`endif
                     r_state <= ST_IDLE;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
            r_wr_ptr        <= r_wr_ptr + c_AW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + c_AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CW'(1);
            2'b01:   r_count <= r_count - c_CW'(1);
            default: ;
         endcase
      end
   end

   assign {m_key, m_tag, m_bytes, m_last} = r_mem[r_rd_ptr];
   assign m_valid   = (r_count != '0);
   assign err_len   = r_err_len;
   assign frame_cnt = r_frame_cnt;
`ifdef PR_TRAILER_CHECK_EN
   assign err_trl   = r_err_trl;
`endif

endmodule
`default_nettype wire
